// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the FIFO-buffered UART transmitter.
//   mem_in_type / mem_out_type : bus slave request and response
//   uart_cfg_type              : packed CONFIG register fields
//   UART_* localparams         : register byte offsets and reset values
//   tx_state_type              : shifter FSM states
//   data_mask / parity_bit     : helpers for 5..8 bit frames
package uart_tx_fifo_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        mem_error;
    } mem_out_type;

    // Bit layout matches the CONFIG register, MSB first.
    typedef struct packed {
        logic [3:0] irq_thresh;   // [11:8]
        logic [1:0] rsvd;         // [7:6], always zero
        logic       irq_en;       // [5]
        logic       two_stop;     // [4]
        logic       par_odd;      // [3]
        logic       par_en;       // [2]
        logic [1:0] dbits;        // [1:0] data bits minus 5
    } uart_cfg_type;

    localparam logic [7:0]  UART_TXDATA    = 8'h00;
    localparam logic [7:0]  UART_STATUS    = 8'h08;
    localparam logic [7:0]  UART_DIVISOR   = 8'h10;
    localparam logic [7:0]  UART_CONFIG    = 8'h18;
    localparam logic [11:0] UART_CFG_RESET = 12'h003;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_type;

    // Mask selecting the low dbits+5 bits of a byte.
    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        return 8'hFF >> (2'd3 - dbits);
    endfunction

    // Parity bit for the used data bits: even makes the total ones count
    // even, odd makes it odd.
    function automatic logic parity_bit(input logic [7:0] data, input uart_cfg_type cfg);
        return (^(data & data_mask(cfg.dbits))) ^ cfg.par_odd;
    endfunction

endpackage

// File: rtl/uart_tx_buffer.sv
// Synchronous first-word-fall-through FIFO.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, wdata  : write request (ignored when full)
//   pop, rdata   : read request (ignored when empty); rdata shows the head
//   full, empty  : status flags
//   level        : occupancy 0..depth, one bit wider than the pointers
module uart_tx_buffer #(
    parameter int depth = 16,
    parameter int width = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         wdata,
    output logic [width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   level
);

    localparam int PTR_W = $clog2(depth);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_LVL = (PTR_W + 1)'(depth);

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == DEPTH_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    // Fullness is judged before any same-cycle pop.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are only visible through level.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter on the memory-mapped peripheral bus.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   uart_in      : bus request (mem_valid, mem_addr, mem_wdata, mem_wstrb)
//   uart_out     : registered bus response (mem_ready, mem_rdata, mem_error)
//   tx_irq       : level interrupt, irq_en && level <= threshold
//   tx           : serial line, idles high
// Registers: 0x00 TXDATA (w), 0x08 STATUS (r), 0x10 DIVISOR (r/w),
// 0x18 CONFIG (r/w). Only mem_addr[7:0] is decoded; the peripheral
// select is made upstream.
// Shifter state lives in r_q.state for observation.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int clock_rate = 217,
    parameter int fifo_depth = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  uart_in,
    output mem_out_type uart_out,
    output logic        tx_irq,
    output logic        tx
);

    localparam int LVL_W = $clog2(fifo_depth) + 1;

    // r/rin two-process register: r_q is r, r_d is rin.
    typedef struct packed {
        tx_state_type state;
        logic [15:0]  cnt;       // cycles spent in the current bit, 0..lat_div
        logic [2:0]   bit_idx;   // data bit being sent
        logic [7:0]   shreg;     // data, LSB on the line
        logic         par;       // parity bit of the frame in flight
        logic [15:0]  lat_div;   // divisor latched for this frame
        uart_cfg_type lat_cfg;   // config latched for this frame
        logic         tx;
        logic [15:0]  divisor;
        uart_cfg_type cfg;
        mem_out_type  bus;
    } reg_type;

    localparam reg_type RES = '{
        state:   TX_IDLE,
        cnt:     16'd0,
        bit_idx: 3'd0,
        shreg:   8'd0,
        par:     1'b0,
        lat_div: 16'd0,
        lat_cfg: uart_cfg_type'(UART_CFG_RESET),
        tx:      1'b1,
        divisor: 16'(clock_rate - 1),
        cfg:     uart_cfg_type'(UART_CFG_RESET),
        bus:     '0
    };

    reg_type r_q, r_d;

    logic             fifo_push, fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             is_write;
    logic [7:0]       reg_addr;
    logic             busy;
    logic             bit_done;
    logic             start_next;
    logic             unused_bits;

    assign unused_bits = ^{uart_in.mem_addr[31:8], uart_in.mem_wdata[31:16]};

    uart_tx_buffer #(
        .depth (fifo_depth),
        .width (8)
    ) u_buffer (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (uart_in.mem_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        r_d        = r_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        is_write   = |uart_in.mem_wstrb;
        reg_addr   = uart_in.mem_addr[7:0];
        busy       = (r_q.state != TX_IDLE);
        bit_done   = (r_q.cnt == r_q.lat_div);
        start_next = 1'b0;

        // Bus: every valid request gets a one-cycle registered response.
        r_d.bus = '0;
        if (uart_in.mem_valid) begin
            r_d.bus.mem_ready = 1'b1;
            case (reg_addr)
                UART_TXDATA: begin
                    if (!is_write || fifo_full) r_d.bus.mem_error = 1'b1;
                    else                        fifo_push = 1'b1;
                end
                UART_STATUS: begin
                    if (is_write) r_d.bus.mem_error = 1'b1;
                    else r_d.bus.mem_rdata = {16'd0, 8'(fifo_level), 5'd0,
                                              busy, fifo_empty, fifo_full};
                end
                UART_DIVISOR: begin
                    if (is_write) r_d.divisor = uart_in.mem_wdata[15:0];
                    else          r_d.bus.mem_rdata = {16'd0, r_q.divisor};
                end
                UART_CONFIG: begin
                    if (is_write) begin
                        r_d.cfg      = uart_cfg_type'(uart_in.mem_wdata[11:0]);
                        r_d.cfg.rsvd = 2'b00;
                    end else begin
                        r_d.bus.mem_rdata = {20'd0, r_q.cfg};
                    end
                end
                default: r_d.bus.mem_error = 1'b1;
            endcase
        end

        // The line is registered from the current state, so it trails the
        // state register by one cycle.
        case (r_q.state)
            TX_START:  r_d.tx = 1'b0;
            TX_DATA:   r_d.tx = r_q.shreg[0];
            TX_PARITY: r_d.tx = r_q.par;
            default:   r_d.tx = 1'b1;
        endcase

        case (r_q.state)
            TX_IDLE:  start_next = 1'b1;
            TX_START: if (bit_done) r_d.state = TX_DATA;
            TX_DATA: begin
                if (bit_done) begin
                    // Last data bit index is dbits+4.
                    if (r_q.bit_idx == {1'b1, r_q.lat_cfg.dbits}) begin
                        r_d.state = r_q.lat_cfg.par_en ? TX_PARITY : TX_STOP1;
                    end else begin
                        r_d.bit_idx = r_q.bit_idx + 3'd1;
                        r_d.shreg   = {1'b0, r_q.shreg[7:1]};
                    end
                end
            end
            TX_PARITY: if (bit_done) r_d.state = TX_STOP1;
            TX_STOP1: begin
                if (bit_done) begin
                    if (r_q.lat_cfg.two_stop) begin
                        r_d.state = TX_STOP2;
                    end else begin
                        r_d.state  = TX_IDLE;
                        start_next = 1'b1;
                    end
                end
            end
            TX_STOP2: begin
                if (bit_done) begin
                    r_d.state  = TX_IDLE;
                    start_next = 1'b1;
                end
            end
            default: r_d.state = TX_IDLE;
        endcase

        if (r_q.state != TX_IDLE) r_d.cnt = bit_done ? 16'd0 : r_q.cnt + 16'd1;

        // Frame start, from idle or straight after the last stop bit.
        // Uses pre-write DIVISOR/CONFIG so a same-cycle write waits a frame.
        if (start_next && !fifo_empty) begin
            fifo_pop    = 1'b1;
            r_d.state   = TX_START;
            r_d.cnt     = 16'd0;
            r_d.bit_idx = 3'd0;
            r_d.shreg   = fifo_rdata;
            r_d.lat_div = r_q.divisor;
            r_d.lat_cfg = r_q.cfg;
            r_d.par     = parity_bit(fifo_rdata, r_q.cfg);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_q <= RES;
        else       r_q <= r_d;
    end

    assign uart_out = r_q.bus;
    assign tx       = r_q.tx;
    assign tx_irq   = r_q.cfg.irq_en && (16'(fifo_level) <= 16'(r_q.cfg.irq_thresh));

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter that supersedes the single-byte transmitter on the memory-mapped peripheral bus. It adds a TX FIFO, a runtime-programmable baud divisor, 5–8 data bits, optional even/odd parity, one or two stop bits, a status register and a level-triggered threshold interrupt. It has the same bus slave port (mem_in_type/mem_out_type) and `tx`/`tx_irq` outputs as the existing transmitter.

## Interface
- clock_rate, default 217 — reset value of the bit period in clock cycles; divisor register resets to clock_rate-1.
- fifo_depth, default 16 — TX FIFO entries; power of two, ≥2.
- clock  in  1  — the single clock; all logic on its rising edge.
- reset  in  1  — synchronous, active-high reset.
- uart_in  in  mem_in_type  — bus request; uses mem_valid, mem_addr, mem_wdata, mem_wstrb.
- uart_out  out  mem_out_type  — bus response: mem_ready, mem_rdata, mem_error.
- tx_irq  out  1  — level interrupt.
- tx  out  1  — serial line; idles high.

## Operation
Register map (byte offset in mem_addr; a write is |mem_wstrb==1):
- 0x00 TXDATA, write-only: wdata[7:0] is pushed to the FIFO. If the FIFO is full the byte is dropped and mem_error=1.
- 0x08 STATUS, read-only:
  - [0] full, [1] empty, [2] busy (shifter not idle).
  - [15:8] FIFO level, 0..fifo_depth.
- 0x10 DIVISOR, r/w [15:0]: bit period minus 1. A value of 0 gives one cycle per bit.
- 0x18 CONFIG, r/w. Reset value 0x003 (8N1, irq off).
  - [1:0] data bits minus 5.
  - [2] parity enable; [3] odd parity.
  - [4] two stop bits; [5] irq enable.
  - [11:8] irq threshold.

Bus response rules:
- Any other address, a read of TXDATA, or a write to STATUS gives mem_error=1 and no side effect.
- Read data is zero-extended. Writes return mem_rdata=0.

Shifter FSM: IDLE → START → DATA → PARITY → STOP1 → STOP2 → IDLE.
- IDLE: tx=1. If the FIFO is non-empty, pop one byte and latch the byte, DIVISOR and CONFIG, then go to START.
- START: tx=0.
- DATA: LSB first, for the latched number of bits. Unused high bits are ignored.
- PARITY: entered only if parity is enabled. Even parity makes the total count of ones in data+parity even; odd parity makes it odd.
- STOP1: tx=1. Then STOP2 if two stop bits are set, otherwise IDLE.
- Every state except IDLE lasts latched divisor+1 cycles. The bit counter runs 0..divisor and the state advances when counter==divisor.
- DIVISOR/CONFIG writes during a frame affect only the next frame.

Interrupt: tx_irq = irq_en && (level ≤ threshold). It is combinational from registers, so it carries no glitch from bus inputs.

## Timing
- Reset values:
  - tx=1, tx_irq=0.
  - mem_ready=0, mem_error=0, mem_rdata=0.
  - FIFO empty, FSM IDLE.
  - DIVISOR=clock_rate-1, CONFIG=0x003.
- Every access with mem_valid=1 gets mem_ready=1 for exactly one cycle, on the cycle after the request; the response is registered. A master holds mem_valid for at most one cycle per request.
- A TXDATA write sampled at edge N with an empty FIFO and idle shifter: the FIFO is non-empty after N, the pop happens at N+1, and tx goes low after N+2.
- Back-to-back frames: after STOP (or STOP2) the next START follows with no idle gap if the FIFO is non-empty.
- Simultaneous push and pop:
  - Fullness is evaluated before the pop, so a push while full is rejected even if a pop occurs that cycle.
  - A push and pop together when not full leave the level unchanged.
- FIFO pointers are log2(fifo_depth) bits and wrap. The level counter has one extra bit.
- Reset asserted mid-frame: on the next edge tx=1, the FIFO is empty and the FSM is IDLE. The partial frame is abandoned.

## Structure
- Add to package wires: uart_cfg_type (packed CONFIG fields) and the register offset localparams.
- Use one sub-module, uart_tx_buffer: a synchronous FIFO with push, pop, wdata, rdata, full, empty and level, parametrised by depth and width.
- The top contains the bus decode, registers, the shifter FSM in the r/rin two-process style, and the irq logic.

## Test plan
- DIVISOR=3, CONFIG 8N1, write 0x55 → tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high; frame 40 cycles; STATUS busy=1 during the frame.
- CONFIG 7 bits + even parity (0x006), write 0x41 → 7 data bits 1000001, parity bit 0. With odd parity (0x00E) → parity bit 1. With two stop bits → 2 high bit-periods before the next start.
- fifo_depth=4, DIVISOR large, 6 writes → 5 accepted (one popped immediately), 6th gets mem_error=1. STATUS shows full=1, level=4. All accepted bytes are transmitted in order.
- irq_en=1, threshold=1, 3 bytes queued → tx_irq=0 until level drops to 1, then 1 until the register is rewritten.
- Reset pulse mid-DATA → next cycle tx=1, STATUS=empty/not busy, DIVISOR back to clock_rate-1.
- Read 0x20, write 0x08, read 0x00 → mem_ready=1 with mem_error=1 one cycle later, no state change.
